mem_interface: RTL and testbench

- Memory interface unit sitting directly upstream of the 512x32 synchronous RAM in the Mini-SRC datapath.
- Owns the MAR and MDR registers and converts single-word control-unit requests into correctly timed RAM read/write strobes.
- The RAM has a one-cycle registered read, so this block hides that latency behind a req/ack handshake to the control unit.

---
 rtl/mem_if_pkg.sv | 15 +
 rtl/mem_interface.sv | 111 +++++++++++
 tb/tb_mem_interface.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// Shared widths and state encoding for the Mini-SRC memory interface.
package mem_if_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/mem_interface.sv
// MAR/MDR owner and RAM strobe sequencer for the 512x32 registered-read RAM.
// Optional feature: define MEM_ADDR_CHECK_EN to fault out-of-range addresses.
module mem_interface
  import mem_if_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [DATA_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              mem_ack,
  output logic              busy,
  output logic [DATA_W-1:0] rdata_out,
  output logic              addr_fault,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  state_t              state;
  logic [ADDR_W-1:0]   mar;
  logic [DATA_W-1:0]   mdr;
  logic                fault_q;
  logic                addr_bad;

`ifdef MEM_ADDR_CHECK_EN
  assign addr_bad = |addr_in[DATA_W-1:ADDR_W];
`else
  // Upper address bits alias onto the RAM; they are intentionally dropped.
  logic unused_upper;
  assign unused_upper = ^addr_in[DATA_W-1:ADDR_W];
  assign addr_bad     = 1'b0;
`endif

  assign ram_address = mar;
  assign ram_data_in = mdr;
  assign rdata_out   = mdr;
  assign addr_fault  = fault_q;

  // Access sequencer; all strobes are registered so nothing depends combinationally on mem_req.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state     <= IDLE;
      mar       <= '0;
      mdr       <= '0;
      mem_ack   <= 1'b0;
      busy      <= 1'b0;
      ram_read  <= 1'b0;
      ram_write <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req) begin
            mar  <= addr_in[ADDR_W-1:0];
            busy <= 1'b1;
            if (addr_bad) begin
              state   <= DONE;
              mem_ack <= 1'b1;
              fault_q <= 1'b1;
            end else if (mem_we) begin
              mdr       <= wdata_in;
              ram_write <= 1'b1;
              state     <= WR;
            end else begin
              ram_read <= 1'b1;
              state    <= RD_ADDR;
            end
          end else begin
            state <= IDLE;
          end
        end
        RD_ADDR: begin
          ram_read <= 1'b0;
          state    <= RD_DATA;
        end
        RD_DATA: begin
          mdr     <= ram_data_out;
          mem_ack <= 1'b1;
          state   <= DONE;
        end
        WR: begin
          ram_write <= 1'b0;
          mem_ack   <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          mem_ack <= 1'b0;
          fault_q <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          mem_ack   <= 1'b0;
          fault_q   <= 1'b0;
          busy      <= 1'b0;
          ram_read  <= 1'b0;
          ram_write <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_interface.sv
// Scoreboard bench for mem_interface with a behavioural RAM underneath it.
module tb_mem_interface;
  import mem_if_pkg::*;

`ifdef MEM_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] addr_in = 32'd0;
  logic [31:0] wdata_in = 32'd0;
  logic        mem_ack, busy, addr_fault, ram_read, ram_write;
  logic [31:0] rdata_out, ram_data_in;
  logic [8:0]  ram_address;
  logic [31:0] ram_data_out = 32'd0;

  logic [31:0] ram     [0:511];
  logic [31:0] ref_mem [0:511];

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    bit          fault;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int checks = 0;
  int passed = 0;
  logic prev_ack = 1'b0;

  mem_interface dut (
    .clock(clock), .clear(clear), .mem_req(mem_req), .mem_we(mem_we),
    .addr_in(addr_in), .wdata_in(wdata_in), .mem_ack(mem_ack), .busy(busy),
    .rdata_out(rdata_out), .addr_fault(addr_fault), .ram_read(ram_read),
    .ram_write(ram_write), .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out)
  );

  always #5 clock = ~clock;

  // The 512x32 RAM with a one-cycle registered read.
  always @(posedge clock) begin
    if (ram_write) ram[ram_address] <= ram_data_in;
    if (ram_read)  ram_data_out <= ram[ram_address];
  end

  function automatic logic [31:0] init_word(input int i);
    if (i == 0) return 32'h0100_0095;
    return 32'h5A00_0000 ^ (i * 32'h0001_0101);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  // Monitor: pops the scoreboard whenever the DUT acknowledges.
  always @(negedge clock) begin
    if (!clear) begin
      check("rd_wr_exclusive", {31'd0, ram_read & ram_write}, 32'd0);
      if (mem_ack) begin
        check("ack_single_cycle", {31'd0, prev_ack}, 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("addr_fault", {31'd0, addr_fault}, {31'd0, mon_e.fault});
          if (mon_e.is_read) check("rdata", rdata_out, mon_e.data);
        end
      end
      prev_ack = mem_ack;
    end else begin
      prev_ack = 1'b0;
    end
  end

  task automatic wait_idle();
    int guard = 0;
    @(negedge clock);
    while (busy && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] d);
    bit bad, addr_ok;
    int exp_lat, lat, wcnt, rcnt;
    logic [8:0] idx;
    exp_t e;
    idx = a[8:0];
    bad = CHK && (a[31:9] != 23'd0);
    wait_idle();
    e.fault = bad;
    e.is_read = !we && !bad;
    e.data = 32'd0;
    if (!bad) begin
      if (we) ref_mem[idx] = d;
      else e.data = ref_mem[idx];
    end
    exp_lat = bad ? 1 : (we ? 2 : 3);
    sb.push_back(e);
    mem_req = 1'b1; mem_we = we; addr_in = a; wdata_in = d;
    @(posedge clock); #1;
    mem_req = 1'b0; mem_we = 1'b0; addr_in = $urandom; wdata_in = $urandom;
    lat = 1; wcnt = 0; rcnt = 0; addr_ok = 1'b1;
    while (!mem_ack && lat < 10) begin
      if (ram_write) wcnt++;
      if (ram_read) rcnt++;
      if (!bad && ram_address !== idx) addr_ok = 1'b0;
      @(posedge clock); #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    check("busy_at_ack", {31'd0, busy}, 32'd1);
    check("ram_write_cycles", wcnt, (we && !bad) ? 32'd1 : 32'd0);
    check("ram_read_cycles", rcnt, (!we && !bad) ? 32'd1 : 32'd0);
    if (!bad) check("mar_stable", {31'd0, addr_ok}, 32'd1);
    if (e.is_read) begin
      @(posedge clock); #1;
      check("rdata_hold", rdata_out, e.data);
    end
  endtask

  initial begin
    int cyc, acks, last;
    logic [31:0] a;
    for (int i = 0; i < 512; i++) begin
      ram[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end

    // Reset state
    #12;
    check("rst_ack", {31'd0, mem_ack}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ram_read", {31'd0, ram_read}, 32'd0);
    check("rst_ram_write", {31'd0, ram_write}, 32'd0);
    check("rst_fault", {31'd0, addr_fault}, 32'd0);
    check("rst_rdata", rdata_out, 32'd0);
    check("rst_address", {23'd0, ram_address}, 32'd0);
    @(negedge clock); clear = 1'b0;

    // Directed: read after reset, write/read, wrap-or-fault
    issue(1'b0, 32'h0000_0000, 32'd0);
    issue(1'b1, 32'h0000_0005, 32'hDEAD_BEEF);
    issue(1'b0, 32'h0000_0005, 32'd0);
    issue(1'b1, 32'h0000_0205, 32'hA5A5_A5A5);
    issue(1'b0, 32'h0000_0005, 32'd0);

    // mem_req held high: one read per 4 cycles
    wait_idle();
    for (int k = 0; k < 4; k++) begin
      mon_e.is_read = 1'b1; mon_e.fault = 1'b0; mon_e.data = ref_mem[9'h010];
      sb.push_back(mon_e);
    end
    mem_req = 1'b1; mem_we = 1'b0; addr_in = 32'h0000_0010;
    cyc = 0; acks = 0; last = -1;
    while (acks < 4 && cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
      if (busy) check("hold_address", {23'd0, ram_address}, 32'h10);
      if (mem_ack) begin
        if (last >= 0) check("ack_spacing", cyc - last, 32'd4);
        last = cyc;
        acks++;
      end
    end
    mem_req = 1'b0;
    check("hold_acks", acks, 32'd4);
    repeat (6) @(negedge clock);
    check("hold_no_extra", sb.size(), 32'd0);

    // Clear in the WR cycle aborts the write
    wait_idle();
    mem_req = 1'b1; mem_we = 1'b1; addr_in = 32'h0000_0020; wdata_in = 32'h1234_5678;
    @(posedge clock); #1;
    mem_req = 1'b0; mem_we = 1'b0;
    check("abort_wr_strobe", {31'd0, ram_write}, 32'd1);
    #2 clear = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ram_write", {31'd0, ram_write}, 32'd0);
    check("abort_ack", {31'd0, mem_ack}, 32'd0);
    @(negedge clock); clear = 1'b0;
    acks = 0;
    repeat (4) begin
      @(posedge clock); #1;
      if (mem_ack) acks++;
    end
    check("abort_no_ack", acks, 32'd0);
    issue(1'b0, 32'h0000_0020, 32'd0);

    // Randomized traffic against the reference memory
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    a = $urandom;
        2, 3:    a = 32'h0000_0200 | 32'($urandom_range(0, 15));
        default: a = 32'($urandom_range(0, 31));
      endcase
      issue(1'($urandom_range(0, 1)), a, $urandom);
    end

    repeat (6) @(negedge clock);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
